// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset datapath: FSM states,
// opcode/funct encodings, instruction classes and immediate handling.
package mc_pkg;

  typedef logic [2:0] state_t;
  localparam state_t S_FETCH  = 3'd0;
  localparam state_t S_DECODE = 3'd1;
  localparam state_t S_EXEC   = 3'd2;
  localparam state_t S_MEM    = 3'd3;
  localparam state_t S_WB     = 3'd4;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_ORI = 6'h0d;
  localparam logic [5:0] OP_LUI = 6'h0f;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_JAL = 6'h03;

  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_JR   = 6'h08;

  typedef enum logic [3:0] {
    K_NOP, K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_JAL
  } kind_t;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_OR, ALU_PASS} alu_op_t;

  // Anything not recognised (including the all-zero nop) decodes as K_NOP.
  function automatic kind_t decode_kind(input logic [31:0] ir);
    kind_t k;
    k = K_NOP;
    case (ir[31:26])
      OP_R: begin
        case (ir[5:0])
          FN_ADDU: k = K_ADDU;
          FN_SUBU: k = K_SUBU;
          FN_JR:   k = K_JR;
          default: k = K_NOP;
        endcase
      end
      OP_ORI:  k = K_ORI;
      OP_LUI:  k = K_LUI;
      OP_LW:   k = K_LW;
      OP_SW:   k = K_SW;
      OP_BEQ:  k = K_BEQ;
      OP_JAL:  k = K_JAL;
      default: k = K_NOP;
    endcase
    return k;
  endfunction

  function automatic alu_op_t alu_op_of(input kind_t k);
    alu_op_t op;
    case (k)
      K_SUBU:  op = ALU_SUB;
      K_ORI:   op = ALU_OR;
      K_LUI:   op = ALU_PASS;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic [31:0] ext_imm(input kind_t k, input logic [15:0] imm);
    logic [31:0] v;
    case (k)
      K_ORI:   v = {16'h0000, imm};
      K_LUI:   v = {imm, 16'h0000};
      default: v = {{16{imm[15]}}, imm};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// General-purpose register file: two asynchronous read ports, one synchronous
// write port; register 0 is never written and always reads as zero.
module mc_regfile
  import mc_pkg::*;
#(
  parameter int NREGS = 32,
  localparam int AW = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [31:0]   wd,
  output logic [31:0]   rd1,
  output logic [31:0]   rd2
);

  logic [31:0] regs [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? 32'h0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? 32'h0 : regs[ra2];

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB sequencing over a single
// req/ack memory port, with a write-back/retire trace for external checking.
module mc_datapath
  import mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          NREGS    = 32,
  parameter int          JAL_REG  = 31
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_en,
  output logic [31:0] wb_pc,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        retire
);

  localparam int AW = $clog2(NREGS);

  state_t      state_reg;
  logic [31:0] pc_reg, ir_reg, a_reg, b_reg, imm_reg, alu_reg, mdr_reg;

  kind_t       kind;
  logic [31:0] rf_rd1, rf_rd2, pc_plus4, br_off, alu_b, alu_y, rf_wd;
  logic        rf_we, is_rtype;
  logic [4:0]  rf_wa;

  assign kind     = decode_kind(ir_reg);
  assign is_rtype = (kind == K_ADDU) || (kind == K_SUBU);
  assign pc_plus4 = pc_reg + 32'd4;
  assign br_off   = {{14{ir_reg[15]}}, ir_reg[15:0], 2'b00};

  mc_regfile #(.NREGS(NREGS)) u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (AW'(ir_reg[25:21])),
    .ra2 (AW'(ir_reg[20:16])),
    .we  (rf_we),
    .wa  (AW'(rf_wa)),
    .wd  (rf_wd),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2)
  );

  assign alu_b = is_rtype ? b_reg : imm_reg;

  always_comb begin
    alu_y = a_reg + alu_b;
    case (alu_op_of(kind))
      ALU_SUB:  alu_y = a_reg - alu_b;
      ALU_OR:   alu_y = a_reg | alu_b;
      ALU_PASS: alu_y = alu_b;
      default:  alu_y = a_reg + alu_b;
    endcase
  end

  // The single write port serves jal's link write in DECODE and normal WB.
  always_comb begin
    rf_we = 1'b0;
    rf_wa = ir_reg[20:16];
    rf_wd = alu_reg;
    if (state_reg == S_DECODE && kind == K_JAL) begin
      rf_we = 1'b1;
      rf_wa = 5'(JAL_REG);
      rf_wd = pc_plus4;
    end else if (state_reg == S_WB) begin
      rf_we = 1'b1;
      if (is_rtype) rf_wa = ir_reg[15:11];
      if (kind == K_LW) rf_wd = mdr_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_FETCH;
      pc_reg    <= RESET_PC;
      ir_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      imm_reg   <= '0;
      alu_reg   <= '0;
      mdr_reg   <= '0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (mem_ack) begin
            ir_reg    <= mem_rdata;
            state_reg <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_reg     <= rf_rd1;
          b_reg     <= rf_rd2;
          imm_reg   <= ext_imm(kind, ir_reg[15:0]);
          state_reg <= S_FETCH;
          // Control-flow and unknown instructions complete here.
          case (kind)
            K_BEQ:   pc_reg <= (rf_rd1 == rf_rd2) ? pc_plus4 + br_off : pc_plus4;
            K_JAL:   pc_reg <= {pc_plus4[31:28], ir_reg[25:0], 2'b00};
            K_JR:    pc_reg <= rf_rd1;
            K_NOP:   pc_reg <= pc_plus4;
            default: state_reg <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          alu_reg   <= alu_y;
          state_reg <= (kind == K_LW || kind == K_SW) ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (mem_ack) begin
            if (kind == K_SW) begin
              pc_reg    <= pc_plus4;
              state_reg <= S_FETCH;
            end else begin
              mdr_reg   <= mem_rdata;
              state_reg <= S_WB;
            end
          end
        end
        S_WB: begin
          pc_reg    <= pc_plus4;
          state_reg <= S_FETCH;
        end
        default: state_reg <= S_FETCH;
      endcase
    end
  end

  // Gating with rst drops an in-flight request in the same cycle reset rises.
  assign mem_req   = (state_reg == S_FETCH || state_reg == S_MEM) && !rst;
  assign mem_we    = (state_reg == S_MEM) && (kind == K_SW) && !rst;
  assign mem_addr  = (state_reg == S_FETCH) ? {pc_reg[31:2], 2'b00} :
                     (state_reg == S_MEM)   ? {alu_reg[31:2], 2'b00} : 32'h0;
  assign mem_wdata = mem_we ? b_reg : 32'h0;

  assign wb_en   = rf_we;
  assign wb_pc   = rf_we ? pc_reg : 32'h0;
  assign wb_reg  = rf_we ? rf_wa : 5'd0;
  assign wb_data = rf_we ? rf_wd : 32'h0;

  assign retire = (state_reg == S_DECODE &&
                   (kind == K_BEQ || kind == K_JAL || kind == K_JR || kind == K_NOP)) ||
                  (state_reg == S_MEM && kind == K_SW && mem_ack) ||
                  (state_reg == S_WB);

endmodule

// File: tb/tb_mc_datapath.sv
// Self-checking bench for mc_datapath: behavioural variable-latency memory plus a
// write-back scoreboard filled when each program is loaded.
module tb_mc_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        wb_en, retire;
  logic [31:0] wb_pc, wb_data;
  logic [4:0]  wb_reg;

  always #5 clk = ~clk;

  mc_datapath dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .wb_en     (wb_en),
    .wb_pc     (wb_pc),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .retire    (retire)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  r;
    logic [31:0] d;
  } wb_t;

  wb_t         exp_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] mem [4096];
  int total = 0, bad = 0;
  int cyc, ret_cnt, ack_cnt, mem_wait, st_req_cycles, req_seen_cyc, wb_seen_cyc;
  logic [31:0] st_addr, st_data;

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic load(input logic [31:0] addr, input logic [31:0] w);
    mem[addr[13:2]] = w;
  endtask

  // One clock: drive memory response at negedge, then sample DUT outputs.
  task automatic tick();
    wb_t e;
    @(negedge clk);
    mem_ack   = mem_req && (ack_cnt >= mem_wait);
    mem_rdata = (mem_ack && !mem_we) ? mem[mem_addr[13:2]] : 32'h0;
    if (mem_ack || !mem_req) ack_cnt = 0;
    else ack_cnt++;
    #1;
    cyc++;
    if (mem_req && req_seen_cyc < 0) req_seen_cyc = cyc;
    if (mem_req && mem_we) st_req_cycles++;
    if (mem_req && mem_ack && mem_we) begin
      mem[mem_addr[13:2]] = mem_wdata;
      st_addr = mem_addr;
      st_data = mem_wdata;
      $display("store addr=%h data=%h", mem_addr, mem_wdata);
    end
    if (mem_req && mem_ack && !mem_we) rd_q.push_back(mem_addr);
    if (retire) ret_cnt++;
    if (wb_en) begin
      if (wb_seen_cyc < 0) wb_seen_cyc = cyc;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected: got pc=%h reg=%0d data=%h, required no write", wb_pc, wb_reg, wb_data);
      end else begin
        e = exp_q.pop_front();
        if (wb_pc !== e.pc || wb_reg !== e.r || wb_data !== e.d) begin
          bad++;
          $display("FAIL wb: got pc=%h reg=%0d data=%h, required pc=%h reg=%0d data=%h",
                   wb_pc, wb_reg, wb_data, e.pc, e.r, e.d);
        end else begin
          $display("wb pc=%h reg=%0d data=%h", wb_pc, wb_reg, wb_data);
        end
      end
    end
  endtask

  task automatic do_reset(input int wait_cycles);
    rst = 1'b1;
    mem_wait = wait_cycles;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    exp_q.delete();
    rd_q.delete();
    st_req_cycles = 0;
    ret_cnt = 0;
    cyc = 0;
    req_seen_cyc = -1;
    wb_seen_cyc = -1;
    st_addr = 32'h0;
    st_data = 32'h0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_retires(input string tag, input int n);
    int budget;
    budget = 400;
    while (ret_cnt < n && budget > 0) begin
      tick();
      budget--;
    end
    total++;
    if (ret_cnt < n) begin
      bad++;
      $display("FAIL %s_timeout: retired %0d, required %0d", tag, ret_cnt, n);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_wb_missing: pending %0d, required 0", tag, exp_q.size());
    end
  endtask

  function automatic logic [31:0] rd_at(input int idx);
    return (rd_q.size() > idx) ? rd_q[idx] : 32'hdead_beef;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    total++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_wdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_mem: got req=%b we=%b wdata=%h, required 0 0 0", mem_req, mem_we, mem_wdata);
    end
    total++;
    if (mem_addr !== 32'h3000) begin
      bad++;
      $display("FAIL reset_addr: got %h, required 00003000", mem_addr);
    end
    total++;
    if (wb_en !== 1'b0 || retire !== 1'b0 || wb_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_trace: got wb_en=%b retire=%b wb_data=%h, required 0 0 0", wb_en, retire, wb_data);
    end
    $display("reset checked");
  endtask

  task automatic test_ori();
    do_reset(0);
    load(32'h3000, enc_i(6'h0d, 5'd0, 5'd1, 16'h1234));
    exp_q.push_back('{32'h3000, 5'd1, 32'h0000_1234});
    run_retires("ori", 1);
    total++;
    if (wb_seen_cyc - req_seen_cyc != 3) begin
      bad++;
      $display("FAIL ori_latency: got wb_en %0d cycles after first req cycle, required 3",
               wb_seen_cyc - req_seen_cyc);
    end
  endtask

  task automatic test_alu();
    do_reset(0);
    load(32'h3000, enc_i(6'h0f, 5'd0, 5'd2, 16'hffff));
    load(32'h3004, enc_i(6'h0d, 5'd2, 5'd2, 16'hffff));
    load(32'h3008, enc_r(5'd2, 5'd2, 5'd3, 6'h21));
    load(32'h300c, enc_r(5'd0, 5'd2, 5'd4, 6'h23));
    exp_q.push_back('{32'h3000, 5'd2, 32'hffff_0000});
    exp_q.push_back('{32'h3004, 5'd2, 32'hffff_ffff});
    exp_q.push_back('{32'h3008, 5'd3, 32'hffff_fffe});
    exp_q.push_back('{32'h300c, 5'd4, 32'h0000_0001});
    run_retires("alu", 4);
  endtask

  task automatic test_mem_wait();
    do_reset(2);
    load(32'h3000, enc_i(6'h0f, 5'd0, 5'd3, 16'hffff));
    load(32'h3004, enc_i(6'h0d, 5'd3, 5'd3, 16'hfffe));
    load(32'h3008, enc_i(6'h2b, 5'd0, 5'd3, 16'h0004));
    load(32'h300c, enc_i(6'h23, 5'd0, 5'd5, 16'h0004));
    load(32'h3010, enc_i(6'h23, 5'd0, 5'd7, 16'h0006));
    exp_q.push_back('{32'h3000, 5'd3, 32'hffff_0000});
    exp_q.push_back('{32'h3004, 5'd3, 32'hffff_fffe});
    exp_q.push_back('{32'h300c, 5'd5, 32'hffff_fffe});
    exp_q.push_back('{32'h3010, 5'd7, 32'hffff_fffe});
    run_retires("mem", 5);
    total++;
    if (st_addr !== 32'h4 || st_data !== 32'hffff_fffe) begin
      bad++;
      $display("FAIL sw_bus: got addr=%h data=%h, required addr=00000004 data=fffffffe", st_addr, st_data);
    end
    total++;
    if (st_req_cycles != 3) begin
      bad++;
      $display("FAIL sw_req_hold: got %0d cycles, required 3", st_req_cycles);
    end
    total++;
    if (rd_at(rd_q.size() - 1) !== 32'h4) begin
      bad++;
      $display("FAIL lw_unaligned_addr: got %h, required 00000004", rd_at(rd_q.size() - 1));
    end
  endtask

  task automatic test_branch();
    do_reset(0);
    load(32'h3010, enc_i(6'h04, 5'd0, 5'd0, 16'hffff));
    run_retires("beq_taken", 6);
    total++;
    if (rd_at(5) !== 32'h3010) begin
      bad++;
      $display("FAIL beq_taken: got fetch %h, required 00003010", rd_at(5));
    end

    do_reset(0);
    load(32'h3000, enc_i(6'h0d, 5'd0, 5'd1, 16'h0001));
    load(32'h3010, enc_i(6'h04, 5'd0, 5'd1, 16'hffff));
    load(32'h3020, {6'h03, 26'h000_0c10});
    load(32'h3040, enc_r(5'd31, 5'd0, 5'd0, 6'h08));
    exp_q.push_back('{32'h3000, 5'd1, 32'h0000_0001});
    exp_q.push_back('{32'h3020, 5'd31, 32'h0000_3024});
    run_retires("jump", 11);
    total++;
    if (rd_at(5) !== 32'h3014) begin
      bad++;
      $display("FAIL beq_not_taken: got fetch %h, required 00003014", rd_at(5));
    end
    total++;
    if (rd_at(9) !== 32'h3040) begin
      bad++;
      $display("FAIL jal_target: got fetch %h, required 00003040", rd_at(9));
    end
    total++;
    if (rd_at(10) !== 32'h3024) begin
      bad++;
      $display("FAIL jr_target: got fetch %h, required 00003024", rd_at(10));
    end
  endtask

  task automatic test_zero_and_unknown();
    do_reset(0);
    load(32'h3000, enc_i(6'h0d, 5'd0, 5'd1, 16'h0005));
    load(32'h3004, enc_r(5'd1, 5'd1, 5'd0, 6'h21));
    load(32'h3008, enc_r(5'd0, 5'd1, 5'd6, 6'h21));
    load(32'h300c, enc_i(6'h3f, 5'd0, 5'd0, 16'h0000));
    load(32'h3010, enc_i(6'h0d, 5'd0, 5'd7, 16'h0007));
    exp_q.push_back('{32'h3000, 5'd1, 32'h0000_0005});
    exp_q.push_back('{32'h3004, 5'd0, 32'h0000_000a});
    exp_q.push_back('{32'h3008, 5'd6, 32'h0000_0005});
    exp_q.push_back('{32'h3010, 5'd7, 32'h0000_0007});
    run_retires("zero", 5);
    total++;
    if (rd_at(4) !== 32'h3010) begin
      bad++;
      $display("FAIL unknown_op_pc: got fetch %h, required 00003010", rd_at(4));
    end
  endtask

  task automatic test_reset_mid_mem();
    int budget;
    do_reset(3);
    load(32'h3000, enc_i(6'h23, 5'd0, 5'd5, 16'h0004));
    mem[1] = 32'h0000_0055;
    budget = 60;
    while (!(mem_req && !mem_we && mem_addr == 32'h4) && budget > 0) begin
      tick();
      budget--;
    end
    total++;
    if (budget == 0) begin
      bad++;
      $display("FAIL rst_mid_reach_mem: lw data request not seen, required within 60 cycles");
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (mem_req !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_req_drop: got mem_req=%b, required 0", mem_req);
    end
    rd_q.delete();
    tick();
    tick();
    tick();
    rst = 1'b0;
    budget = 60;
    while (rd_q.size() == 0 && budget > 0) begin
      tick();
      budget--;
    end
    total++;
    if (rd_at(0) !== 32'h3000) begin
      bad++;
      $display("FAIL rst_mid_refetch: got fetch %h, required 00003000", rd_at(0));
    end
    $display("reset during lw checked");
  endtask

  initial begin
    rst       = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    ack_cnt   = 0;
    mem_wait  = 0;
    cyc = 0;
    ret_cnt = 0;
    st_req_cycles = 0;
    req_seen_cyc = -1;
    wb_seen_cyc = -1;
    #2;
    test_reset();
    test_ori();
    test_alu();
    test_mem_wait();
    test_branch();
    test_zero_and_unknown();
    test_reset_mid_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
